alu_operand_sequencer: RTL

//  Input-side companion of the ALU display top: turns one-cycle debounced button pulses and the

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_operand_sequencer_if.sv | 24 ++
 rtl/alu_operand_sequencer_op_select.sv | 27 ++
 rtl/alu_operand_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand-entry path.
package alu_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned NUM_OPS_DEF = 5;
  localparam int unsigned OP_W_DEF    = 3;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    PRESENT = 2'd3
  } seq_state_t;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND = 3'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 3'd4;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand-set handoff bus between the sequencer (master) and the ALU/display path (slave).
interface alu_operand_sequencer_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OP_W  = OP_W_DEF
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OP_W-1:0]  opcode;
  logic [1:0]       stage;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output op_a, op_b, opcode, stage, out_valid,
    input  out_ready
  );

  modport slave (
    input  op_a, op_b, opcode, stage, out_valid,
    output out_ready
  );
endinterface

// File: rtl/alu_operand_sequencer_op_select.sv
// Modulo-NUM_OPS up/down opcode counter; up wins over down, out-of-range values recover to 0.
module op_select_counter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_OPS = NUM_OPS_DEF,
  parameter int unsigned OP_W    = OP_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            up,
  input  logic            down,
  output logic [OP_W-1:0] count
);
  localparam logic [OP_W-1:0] MAX = OP_W'(NUM_OPS - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count > MAX) begin
      count <= '0;
    end else if (up) begin
      count <= (count == MAX) ? '0 : count + OP_W'(1);
    end else if (down) begin
      count <= (count == '0) ? MAX : count - OP_W'(1);
    end
  end
endmodule

// File: rtl/alu_operand_sequencer.sv
// Turns debounced button pulses and the switch word into an (A, B, opcode) set handed off via valid/ready.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned NUM_OPS = NUM_OPS_DEF,
  parameter int unsigned OP_W    = OP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sw,
  input  logic                     pb_confirm,
  input  logic                     pb_back,
  input  logic                     pb_up,
  input  logic                     pb_down,
  alu_operand_sequencer_if.master  bus
);
  localparam logic [1:0] S_LOAD_A  = 2'(LOAD_A);
  localparam logic [1:0] S_LOAD_B  = 2'(LOAD_B);
  localparam logic [1:0] S_LOAD_OP = 2'(LOAD_OP);
  localparam logic [1:0] S_PRESENT = 2'(PRESENT);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [OP_W-1:0]  opcode_q;
  logic             out_valid_q;
  logic             cap_a;
  logic             cap_b;
  logic             op_up;
  logic             op_down;

  // Next state and capture strobes; pulse priority is confirm > back > up > down.
  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    op_up     = 1'b0;
    op_down   = 1'b0;
    case (state)
      S_LOAD_A: begin
        if (pb_confirm) begin
          cap_a     = 1'b1;
          state_nxt = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (pb_confirm) begin
          cap_b     = 1'b1;
          state_nxt = S_LOAD_OP;
        end else if (pb_back) begin
          state_nxt = S_LOAD_A;
        end
      end
      S_LOAD_OP: begin
        if (pb_confirm) begin
          state_nxt = S_PRESENT;
        end else if (pb_back) begin
          state_nxt = S_LOAD_B;
        end else if (pb_up) begin
          op_up = 1'b1;
        end else if (pb_down) begin
          op_down = 1'b1;
        end
      end
      S_PRESENT: begin
        // Handshake beats back; operands stay frozen while valid is high.
        if (out_valid_q && bus.out_ready) begin
          state_nxt = S_LOAD_A;
        end else if (pb_back) begin
          state_nxt = S_LOAD_OP;
        end
      end
      default: state_nxt = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt == S_PRESENT);
      if (cap_a) op_a_q <= sw;
      if (cap_b) op_b_q <= sw;
    end
  end

  op_select_counter #(
    .NUM_OPS (NUM_OPS),
    .OP_W    (OP_W)
  ) u_op_select (
    .clk   (clk),
    .reset (reset),
    .up    (op_up),
    .down  (op_down),
    .count (opcode_q)
  );

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.opcode    = opcode_q;
  assign bus.stage     = state;
  assign bus.out_valid = out_valid_q;
endmodule
